// File: rtl/ram_ctl_if.sv
// Request/response bundle between the tinycpu memory stage (master) and ram_ctl (slave).
// The parity side-band signals exist only when RAM_PARITY_EN is defined.
interface ram_ctl_if #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 12
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [AWIDTH-1:0] req_addr;
  logic [DWIDTH-1:0] req_wdata;
  logic              rsp_valid;
  logic [DWIDTH-1:0] rsp_rdata;
  logic              init_busy;
`ifdef RAM_PARITY_EN
  logic              inj_perr;
  logic              rsp_perr;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, inj_perr,
    input  req_ready, rsp_valid, rsp_rdata, init_busy, rsp_perr
  );
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, inj_perr,
    output req_ready, rsp_valid, rsp_rdata, init_busy, rsp_perr
  );
`else
  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, init_busy
  );
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, init_busy
  );
`endif
endinterface

// File: rtl/ram_ctl.sv
// Single-port word RAM for tinycpu: zeroing init sweep after reset, valid/ready requests,
// read latency 1 (OREG=0) or 2 (OREG=1). Define RAM_PARITY_EN for a stored even-parity bit.
module ram_ctl #(
  parameter int DWIDTH   = 16,
  parameter int AWIDTH   = 12,
  parameter int WORDS    = 4096,
  parameter int RDW_MODE = 0,
  parameter int OREG     = 0
) (
  input  logic      clk,
  input  logic      rst_n,
  ram_ctl_if.slave  bus
);

  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
`ifdef RAM_PARITY_EN
  localparam int WW = DWIDTH + 1;
`else
  localparam int WW = DWIDTH;
`endif
  localparam logic [AWIDTH:0] WORDS_W  = (AWIDTH+1)'(WORDS);
  localparam logic [IW-1:0]   LAST_IDX = IW'(WORDS - 1);

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e            state_q, state_d;
  logic [IW-1:0]     init_cnt_q, init_cnt_d;

  logic              in_range;
  logic              rd_acc;
  logic              mem_we;
  logic [IW-1:0]     mem_idx;
  logic [WW-1:0]     mem_wword;
  logic [WW-1:0]     req_word;
  logic [WW-1:0]     rd_word;
  logic [DWIDTH-1:0] rd_data;
  logic [WW-1:0]     mem [WORDS];

  logic              v1_q;
  logic [DWIDTH-1:0] d1_q;

  assign in_range = {1'b0, bus.req_addr} < WORDS_W;
  assign rd_acc   = bus.req_valid && bus.req_ready && !bus.req_we;

`ifdef RAM_PARITY_EN
  assign req_word = {(^bus.req_wdata) ^ bus.inj_perr, bus.req_wdata};
`else
  assign req_word = bus.req_wdata;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  // The sweep owns the array port during INIT; requests are refused until RUN.
  always_comb begin
    state_d        = state_q;
    init_cnt_d     = init_cnt_q;
    bus.req_ready  = 1'b0;
    bus.init_busy  = 1'b0;
    mem_we         = 1'b0;
    mem_idx        = bus.req_addr[IW-1:0];
    mem_wword      = req_word;
    case (state_q)
      ST_INIT: begin
        bus.init_busy = 1'b1;
        mem_we        = 1'b1;
        mem_idx       = init_cnt_q;
        mem_wword     = '0;
        if (init_cnt_q == LAST_IDX) state_d    = ST_RUN;
        else                        init_cnt_d = init_cnt_q + IW'(1);
      end
      ST_RUN: begin
        bus.req_ready = 1'b1;
        mem_we        = bus.req_valid && bus.req_we && in_range;
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_idx] <= mem_wword;
  end

  // Write-first bypass selects the array primitive style; with one port a read
  // never coincides with a write, so returned data is the same in both modes.
  always_comb begin
    rd_word = mem[mem_idx];
    if (RDW_MODE != 0 && mem_we) rd_word = mem_wword;
  end

  assign rd_data = in_range ? rd_word[DWIDTH-1:0] : '0;

`ifdef RAM_PARITY_EN
  logic rd_perr;
  logic p1_q;
  assign rd_perr = in_range && (^rd_word);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      d1_q <= '0;
`ifdef RAM_PARITY_EN
      p1_q <= 1'b0;
`endif
    end else begin
      v1_q <= rd_acc;
      if (rd_acc) begin
        d1_q <= rd_data;
`ifdef RAM_PARITY_EN
        p1_q <= rd_perr;
`endif
      end
    end
  end

  generate
    if (OREG != 0) begin : g_oreg
      logic              v2_q;
      logic [DWIDTH-1:0] d2_q;
`ifdef RAM_PARITY_EN
      logic              p2_q;
`endif
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v2_q <= 1'b0;
          d2_q <= '0;
`ifdef RAM_PARITY_EN
          p2_q <= 1'b0;
`endif
        end else begin
          v2_q <= v1_q;
          if (v1_q) begin
            d2_q <= d1_q;
`ifdef RAM_PARITY_EN
            p2_q <= p1_q;
`endif
          end
        end
      end
      assign bus.rsp_valid = v2_q;
      assign bus.rsp_rdata = d2_q;
`ifdef RAM_PARITY_EN
      assign bus.rsp_perr  = p2_q;
`endif
    end else begin : g_noreg
      assign bus.rsp_valid = v1_q;
      assign bus.rsp_rdata = d1_q;
`ifdef RAM_PARITY_EN
      assign bus.rsp_perr  = p1_q;
`endif
    end
  endgenerate

endmodule

// File: tb/tb_ram_ctl.sv
// Bench for ram_ctl: two instances (OREG=0/RDW_MODE=0, WORDS=16 and OREG=1/RDW_MODE=1, WORDS=8)
// share one request stream; responses are checked against an array model with latency queues.
module tb_ram_ctl;
  localparam int DW = 16;
  localparam int AW = 5;
  localparam int WA = 16;
  localparam int WB = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          inj_perr = 1'b0;

  always #5 clk = ~clk;

  ram_ctl_if #(.DWIDTH(DW), .AWIDTH(AW)) ifa ();
  ram_ctl_if #(.DWIDTH(DW), .AWIDTH(AW)) ifb ();

  assign ifa.req_valid = req_valid;
  assign ifa.req_we    = req_we;
  assign ifa.req_addr  = req_addr;
  assign ifa.req_wdata = req_wdata;
  assign ifb.req_valid = req_valid;
  assign ifb.req_we    = req_we;
  assign ifb.req_addr  = req_addr;
  assign ifb.req_wdata = req_wdata;
`ifdef RAM_PARITY_EN
  assign ifa.inj_perr  = inj_perr;
  assign ifb.inj_perr  = inj_perr;
`endif

  ram_ctl #(.DWIDTH(DW), .AWIDTH(AW), .WORDS(WA), .RDW_MODE(0), .OREG(0))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  ram_ctl #(.DWIDTH(DW), .AWIDTH(AW), .WORDS(WB), .RDW_MODE(1), .OREG(1))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            due;
    logic [DW-1:0] d;
    logic          pe;
  } exp_t;

  typedef struct {
    bit            we;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    logic [DW-1:0] ea;
    logic [DW-1:0] eb;
  } vec_t;

  exp_t          qa[$];
  exp_t          qb[$];
  vec_t          tab[$];
  logic [DW-1:0] last_a = '0;
  logic [DW-1:0] last_b = '0;
  logic [DW-1:0] ma[WA];
  logic          pa[WA];
  logic [DW-1:0] mb[WB];
  logic          pb[WB];
  bit            ea_v, eb_v;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < WA; i++) begin ma[i] = '0; pa[i] = 1'b0; end
    for (int i = 0; i < WB; i++) begin mb[i] = '0; pb[i] = 1'b0; end
    qa.delete(); qb.delete();
    last_a = '0; last_b = '0;
  endtask

  // Drive one request slot (called at posedge+1); reads queue their expected responses.
  task automatic req(input bit v, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                     input bit inj, input bit use_tab, input logic [DW-1:0] ea, input logic [DW-1:0] eb);
    int   ai;
    exp_t e;
    ai = int'(a);
    req_valid = v; req_we = we; req_addr = a; req_wdata = wd; inj_perr = inj;
    @(posedge clk); #1;
    if (v && we) begin
      if (ai < WA) begin ma[ai] = wd; pa[ai] = inj; end
      if (ai < WB) begin mb[ai] = wd; pb[ai] = inj; end
    end
    if (v && !we) begin
      e.due = cyc;
      e.d   = use_tab ? ea : ((ai < WA) ? ma[ai] : '0);
      e.pe  = (ai < WA) ? pa[ai] : 1'b0;
      qa.push_back(e);
      e.due = cyc + 1;
      e.d   = use_tab ? eb : ((ai < WB) ? mb[ai] : '0);
      e.pe  = (ai < WB) ? pb[ai] : 1'b0;
      qb.push_back(e);
    end
    req_valid = 1'b0; req_we = 1'b0; inj_perr = 1'b0;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      ea_v = (qa.size() > 0) && (qa[0].due == cyc);
      check("A rsp_valid", {31'b0, ifa.rsp_valid}, {31'b0, ea_v});
      if (ea_v) begin
        last_a = qa[0].d;
`ifdef RAM_PARITY_EN
        check("A rsp_perr", {31'b0, ifa.rsp_perr}, {31'b0, qa[0].pe});
`endif
        void'(qa.pop_front());
      end
      check("A rsp_rdata", {16'b0, ifa.rsp_rdata}, {16'b0, last_a});

      eb_v = (qb.size() > 0) && (qb[0].due == cyc);
      check("B rsp_valid", {31'b0, ifb.rsp_valid}, {31'b0, eb_v});
      if (eb_v) begin
        last_b = qb[0].d;
`ifdef RAM_PARITY_EN
        check("B rsp_perr", {31'b0, ifb.rsp_perr}, {31'b0, qb[0].pe});
`endif
        void'(qb.pop_front());
      end
      check("B rsp_rdata", {16'b0, ifb.rsp_rdata}, {16'b0, last_b});
    end
  end

  // Called at posedge+1 right after rst_n rises: edges 1..WORDS are the sweep.
  task automatic init_check();
    for (int j = 0; j <= WA + 2; j++) begin
      check("A req_ready init", {31'b0, ifa.req_ready}, {31'b0, j >= WA});
      check("A init_busy init", {31'b0, ifa.init_busy}, {31'b0, j < WA});
      check("B req_ready init", {31'b0, ifb.req_ready}, {31'b0, j >= WB});
      check("B init_busy init", {31'b0, ifb.init_busy}, {31'b0, j < WB});
      check("A rsp_valid init", {31'b0, ifa.rsp_valid}, 32'd0);
      check("B rsp_valid init", {31'b0, ifb.rsp_valid}, 32'd0);
      @(posedge clk); #1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " A req_ready"}, {31'b0, ifa.req_ready}, 32'd0);
    check({tag, " A init_busy"}, {31'b0, ifa.init_busy}, 32'd1);
    check({tag, " A rsp_valid"}, {31'b0, ifa.rsp_valid}, 32'd0);
    check({tag, " A rsp_rdata"}, {16'b0, ifa.rsp_rdata}, 32'd0);
    check({tag, " B req_ready"}, {31'b0, ifb.req_ready}, 32'd0);
    check({tag, " B init_busy"}, {31'b0, ifb.init_busy}, 32'd1);
    check({tag, " B rsp_valid"}, {31'b0, ifb.rsp_valid}, 32'd0);
    check({tag, " B rsp_rdata"}, {16'b0, ifb.rsp_rdata}, 32'd0);
  endtask

  task automatic drain();
    repeat (4) req(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    init_check();

    // After the sweep every location reads zero.
    mon_en = 1'b1;
    for (int i = 0; i < WA; i++) req(1'b1, 1'b0, AW'(i), '0, 1'b0, 1'b0, '0, '0);

    tab.push_back('{1'b0, 5'h05, 16'h0000, 16'h0000, 16'h0000});
    tab.push_back('{1'b1, 5'h05, 16'h1234, 16'h0000, 16'h0000});
    tab.push_back('{1'b0, 5'h05, 16'h0000, 16'h1234, 16'h1234});
    tab.push_back('{1'b1, 5'h0A, 16'h1111, 16'h0000, 16'h0000});
    tab.push_back('{1'b0, 5'h0A, 16'h0000, 16'h1111, 16'h0000});
    tab.push_back('{1'b1, 5'h0A, 16'h2222, 16'h0000, 16'h0000});
    tab.push_back('{1'b0, 5'h0A, 16'h0000, 16'h2222, 16'h0000});
    tab.push_back('{1'b1, 5'h03, 16'h1111, 16'h0000, 16'h0000});
    tab.push_back('{1'b1, 5'h03, 16'h2222, 16'h0000, 16'h0000});
    tab.push_back('{1'b0, 5'h03, 16'h0000, 16'h2222, 16'h2222});
    tab.push_back('{1'b1, 5'h09, 16'hBEEF, 16'h0000, 16'h0000});
    tab.push_back('{1'b0, 5'h09, 16'h0000, 16'hBEEF, 16'h0000});
    tab.push_back('{1'b1, 5'h19, 16'hDEAD, 16'h0000, 16'h0000});
    tab.push_back('{1'b0, 5'h19, 16'h0000, 16'h0000, 16'h0000});
    tab.push_back('{1'b0, 5'h09, 16'h0000, 16'hBEEF, 16'h0000});
    tab.push_back('{1'b0, 5'h01, 16'h0000, 16'h0000, 16'h0000});
    tab.push_back('{1'b0, 5'h05, 16'h0000, 16'h1234, 16'h1234});
    foreach (tab[i])
      req(1'b1, tab[i].we, tab[i].a, tab[i].wd, 1'b0, 1'b1, tab[i].ea, tab[i].eb);

    // Streaming: back-to-back writes then back-to-back reads.
    for (int i = 0; i < WA; i++) req(1'b1, 1'b1, AW'(i), 16'hA000 + DW'(i), 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < WA; i++) req(1'b1, 1'b0, AW'(i), '0, 1'b0, 1'b0, '0, '0);

    for (int i = 0; i < 300; i++) begin
      bit inj;
`ifdef RAM_PARITY_EN
      inj = ($urandom_range(0, 3) == 0);
`else
      inj = 1'b0;
`endif
      req($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)),
          DW'($urandom), inj, 1'b0, '0, '0);
    end

`ifdef RAM_PARITY_EN
    req(1'b1, 1'b1, 5'h03, 16'h0F0F, 1'b1, 1'b0, '0, '0);
    req(1'b1, 1'b1, 5'h04, 16'h0F0E, 1'b0, 1'b0, '0, '0);
    req(1'b1, 1'b0, 5'h03, '0, 1'b0, 1'b0, '0, '0);
    req(1'b1, 1'b0, 5'h04, '0, 1'b0, 1'b0, '0, '0);
`endif
    drain();

    // Reset while a read response is on the bus.
    mon_en = 1'b0;
    req(1'b1, 1'b1, 5'h05, 16'h5A5A, 1'b0, 1'b0, '0, '0);
    req(1'b1, 1'b0, 5'h05, '0, 1'b0, 1'b0, '0, '0);
    check("midread A rsp_valid", {31'b0, ifa.rsp_valid}, 32'd1);
    check("midread A rsp_rdata", {16'b0, ifa.rsp_rdata}, 32'h5A5A);
    check("midread B rsp_valid", {31'b0, ifb.rsp_valid}, 32'd0);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midread");
    @(posedge clk); #1;
    check("midread B rsp_valid late", {31'b0, ifb.rsp_valid}, 32'd0);

    // Reset in the middle of the sweep restarts it from address 0.
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1 check("midinit A init_busy", {31'b0, ifa.init_busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midinit");
    @(posedge clk); #1;
    rst_n = 1'b1;
    init_check();

    model_clear();
    mon_en = 1'b1;
    for (int i = 0; i < WA; i++) req(1'b1, 1'b0, AW'(i), '0, 1'b0, 1'b0, '0, '0);
    drain();
    check("A queue empty", qa.size(), 32'd0);
    check("B queue empty", qb.size(), 32'd0);
    mon_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
